// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
// Holds the FSM state encodings, which also drive STATE_LED, and the default
// debounce length.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LAP  = 2'b10,
    ST_STOP = 2'b11
  } state_t;

  localparam int unsigned DEB_CYCLES_DEFAULT = 1024;
  localparam int unsigned DEB_CNT_W          = 16;

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// debounce: 2-flop synchroniser, stability-counter debouncer and rising-edge
// press detector for one raw push button.
//   C      : system clock (rising edge)
//   CLR    : synchronous active-high reset
//   RAW    : asynchronous, bouncing button input (high = pressed)
//   LEVEL  : debounced button level
//   PRESS  : one-cycle pulse in the cycle in which LEVEL is about to rise
module debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic C,
  input  logic CLR,
  input  logic RAW,
  output logic LEVEL,
  output logic PRESS
);

  localparam logic [DEB_CNT_W-1:0] CNT_LIMIT = DEB_CNT_W'(DEB_CYCLES);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 level_q, level_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 press;

  always_comb begin
    sync1_d = RAW;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LIMIT) begin
      // Accept the new level; PRESS is combinational so the FSM updates on
      // the same edge at which LEVEL rises.
      level_d = sync2_q;
      cnt_d   = '0;
      press   = sync2_q;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge C) begin
    if (CLR) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign LEVEL = level_q;
  assign PRESS = press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop + lap/reset controller for a BCD stopwatch.
//   C         : system clock (rising edge)
//   CLR       : synchronous active-high reset
//   BTN_SS    : raw start/stop button
//   BTN_LR    : raw lap/reset button
//   CE        : count enable to the display counter (RUN, LAP)
//   CNT_CLR   : one-cycle counter clear on STOP->IDLE
//   HOLD      : display freeze in LAP and in STOP entered from LAP
//   STATE_LED : current state encoding
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic       C,
  input  logic       CLR,
  input  logic       BTN_SS,
  input  logic       BTN_LR,
  output logic       CE,
  output logic       CNT_CLR,
  output logic       HOLD,
  output logic [1:0] STATE_LED
);

  logic   ss_press, lr_press;
  logic   ss_level_unused, lr_level_unused;

  state_t state_q, state_d;
  logic   ce_q, ce_d;
  logic   hold_q, hold_d;
  logic   cnt_clr_q, cnt_clr_d;

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .C     (C),
    .CLR   (CLR),
    .RAW   (BTN_SS),
    .LEVEL (ss_level_unused),
    .PRESS (ss_press)
  );

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lr (
    .C     (C),
    .CLR   (CLR),
    .RAW   (BTN_LR),
    .LEVEL (lr_level_unused),
    .PRESS (lr_press)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (ss_press) state_d = ST_RUN;
      ST_RUN: begin
        if (ss_press)      state_d = ST_STOP;
        else if (lr_press) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (ss_press)      state_d = ST_STOP;
        else if (lr_press) state_d = ST_RUN;
      end
      ST_STOP: begin
        // Reset wins over restart here only.
        if (lr_press)      state_d = ST_IDLE;
        else if (ss_press) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    ce_d = (state_d == ST_RUN) || (state_d == ST_LAP);

    // HOLD in STOP remembers whether STOP was entered from LAP.
    hold_d = 1'b0;
    if (state_d == ST_LAP) begin
      hold_d = 1'b1;
    end else if (state_d == ST_STOP) begin
      if (state_q == ST_LAP)       hold_d = 1'b1;
      else if (state_q == ST_STOP) hold_d = hold_q;
    end

    cnt_clr_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
  end

  always_ff @(posedge C) begin
    if (CLR) begin
      state_q   <= ST_IDLE;
      ce_q      <= 1'b0;
      hold_q    <= 1'b0;
      cnt_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ce_q      <= ce_d;
      hold_q    <= hold_d;
      cnt_clr_q <= cnt_clr_d;
    end
  end

  assign CE        = ce_q;
  assign CNT_CLR   = cnt_clr_q;
  assign HOLD      = hold_q;
  assign STATE_LED = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  logic       C = 1'b0;
  logic       CLR;
  logic       BTN_SS;
  logic       BTN_LR;
  logic       CE;
  logic       CNT_CLR;
  logic       HOLD;
  logic [1:0] STATE_LED;

  always #5 C = ~C;

  stopwatch_ctrl #(.DEB_CYCLES(4)) dut (
    .C         (C),
    .CLR       (CLR),
    .BTN_SS    (BTN_SS),
    .BTN_LR    (BTN_LR),
    .CE        (CE),
    .CNT_CLR   (CNT_CLR),
    .HOLD      (HOLD),
    .STATE_LED (STATE_LED)
  );

  typedef struct {
    int         cyc;
    logic       ce;
    logic       clr;
    logic       hold;
    logic [1:0] led;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  // Expected output state after the last hand-computed transition.
  logic       m_ce, m_hold;
  logic [1:0] m_led;

  task automatic push(input int d, input logic ce, input logic clr,
                      input logic hold, input logic [1:0] led, input int tag);
    exp_t e;
    e.cyc = cyc + d; e.ce = ce; e.clr = clr; e.hold = hold; e.led = led; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge C);
  endtask

  // Press (and later release) the selected buttons; outputs must be unchanged
  // at edge 6 and show the new state at edge 7 (DEB_CYCLES+3).
  task automatic do_press(input logic ss, input logic lr, input logic nce,
                          input logic nclr, input logic nhold,
                          input logic [1:0] nled, input int tag);
    BTN_SS = ss;
    BTN_LR = lr;
    push(6, m_ce, 1'b0, m_hold, m_led, tag * 10 + 0);
    push(7, nce, nclr, nhold, nled, tag * 10 + 1);
    push(8, nce, 1'b0, nhold, nled, tag * 10 + 2);
    tick(8);
    BTN_SS = 1'b0;
    BTN_LR = 1'b0;
    push(8, nce, 1'b0, nhold, nled, tag * 10 + 3);
    tick(8);
    m_ce = nce; m_hold = nhold; m_led = nled;
  endtask

  // Monitor: compares the DUT against the queue head whose cycle is due.
  initial begin
    exp_t e;
    forever begin
      @(posedge C);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc < cyc || CE !== e.ce || CNT_CLR !== e.clr ||
            HOLD !== e.hold || STATE_LED !== e.led) begin
          failures++;
          $display("FAIL chk%0d cyc=%0d: got ce=%b clr=%b hold=%b led=%b, want ce=%b clr=%b hold=%b led=%b",
                   e.tag, cyc, CE, CNT_CLR, HOLD, STATE_LED, e.ce, e.clr, e.hold, e.led);
        end
      end
    end
  end

  initial begin
    int w;
    CLR    = 1'b1;
    BTN_SS = 1'b0;
    BTN_LR = 1'b0;
    m_ce = 1'b0; m_hold = 1'b0; m_led = 2'b00;

    // Reset state
    @(negedge C);
    push(1, 1'b0, 1'b0, 1'b0, 2'b00, 1);
    tick(2);
    CLR = 1'b0;
    tick(2);

    // Held SS: RUN at edge 7, no change at edge 6, no repeat while held
    BTN_SS = 1'b1;
    push(6, 1'b0, 1'b0, 1'b0, 2'b00, 20);
    push(7, 1'b1, 1'b0, 1'b0, 2'b01, 21);
    tick(12);
    push(1, 1'b1, 1'b0, 1'b0, 2'b01, 22);
    tick(1);
    BTN_SS = 1'b0;
    push(8, 1'b1, 1'b0, 1'b0, 2'b01, 23);
    tick(8);
    m_ce = 1'b1; m_hold = 1'b0; m_led = 2'b01;

    // RUN -> LAP -> STOP (hold kept) -> RUN (hold cleared)
    do_press(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 3);
    do_press(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 4);
    do_press(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 5);
    // RUN -> STOP without hold; STOP -> IDLE with clear; LR ignored in IDLE
    do_press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 6);
    do_press(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 7);
    do_press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8);

    // Bouncing SS 1,0,1,0,1 then stable: one press from the last rise
    BTN_SS = 1'b1; tick(1);
    BTN_SS = 1'b0; tick(1);
    BTN_SS = 1'b1; tick(1);
    BTN_SS = 1'b0; tick(1);
    BTN_SS = 1'b1;
    push(6, 1'b0, 1'b0, 1'b0, 2'b00, 90);
    push(7, 1'b1, 1'b0, 1'b0, 2'b01, 91);
    tick(8);
    BTN_SS = 1'b0;
    push(8, 1'b1, 1'b0, 1'b0, 2'b01, 92);
    tick(8);
    m_ce = 1'b1; m_hold = 1'b0; m_led = 2'b01;

    // Simultaneous presses: LR wins in STOP, SS wins elsewhere
    do_press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 10);
    do_press(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 11);
    do_press(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 12);
    do_press(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 13);
    do_press(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 14);
    do_press(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 15);
    do_press(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 16);
    do_press(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 17);
    do_press(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 18);

    // CLR pulse in LAP while SS is mid-debounce; SS held, re-debounced after
    BTN_SS = 1'b1;
    tick(3);
    CLR = 1'b1;
    push(1, 1'b0, 1'b0, 1'b0, 2'b00, 190);
    tick(1);
    CLR = 1'b0;
    push(6, 1'b0, 1'b0, 1'b0, 2'b00, 191);
    push(7, 1'b1, 1'b0, 1'b0, 2'b01, 192);
    tick(8);
    BTN_SS = 1'b0;
    push(8, 1'b1, 1'b0, 1'b0, 2'b01, 193);
    tick(8);

    w = 0;
    while (sb.size() > 0 && w < 50) begin
      @(negedge C);
      w++;
    end
    if (sb.size() > 0) begin
      $display("FAIL timeout: pending=%0d, required 0", sb.size());
      failures += sb.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
